// File: rtl/imem_arb_pkg.sv
// rtl/imem_arb_pkg.sv - shared types and defaults for the instruction memory arbiter
package imem_arb_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_LD    = 1'b1
    } owner_e;

    localparam int STARVE_MAX_DEF = 8;

endpackage

// File: rtl/imem_arbiter_if.sv
// rtl/imem_arbiter_if.sv - fetch, loader and memory-macro signals of the imem arbiter
// fetch_err exists only when IMEM_ARB_ALIGN_CHECK_EN is defined.
interface imem_arbiter_if #(
    parameter int ADDR_W = 10
);
    logic              fetch_req;
    logic [31:0]       fetch_addr;
    logic              fetch_gnt;
    logic              fetch_rvalid;
    logic [31:0]       fetch_rdata;
`ifdef IMEM_ARB_ALIGN_CHECK_EN
    logic              fetch_err;
`endif
    logic              ld_req;
    logic              ld_we;
    logic [31:0]       ld_addr;
    logic [31:0]       ld_wdata;
    logic              ld_gnt;
    logic              ld_rvalid;
    logic [31:0]       ld_rdata;
    logic              ld_done;
    logic              ld_halt;
    logic              core_hold;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
`ifdef IMEM_ARB_ALIGN_CHECK_EN
        output fetch_err,
`endif
        input  fetch_req, fetch_addr,
        output fetch_gnt, fetch_rvalid, fetch_rdata,
        input  ld_req, ld_we, ld_addr, ld_wdata, ld_done, ld_halt,
        output ld_gnt, ld_rvalid, ld_rdata, core_hold,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
`ifdef IMEM_ARB_ALIGN_CHECK_EN
        input  fetch_err,
`endif
        output fetch_req, fetch_addr,
        input  fetch_gnt, fetch_rvalid, fetch_rdata,
        output ld_req, ld_we, ld_addr, ld_wdata, ld_done, ld_halt,
        input  ld_gnt, ld_rvalid, ld_rdata, core_hold,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/imem_starve_counter.sv
// rtl/imem_starve_counter.sv - saturating count of consecutive denied loader cycles
module imem_starve_counter
    import imem_arb_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam int            CW   = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] MAXV = CW'(STARVE_MAX);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && cnt != MAXV) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign at_max = (cnt == MAXV);

endmodule

// File: rtl/imem_arbiter.sv
// rtl/imem_arbiter.sv - boot sequencer and fetch/loader arbiter for the single-port imem
// Optional misaligned-fetch error response: IMEM_ARB_ALIGN_CHECK_EN.
module imem_arbiter
    import imem_arb_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic           clk,
    input  logic           rst,
    imem_arbiter_if.slave  bus
);

    arb_state_e state;
    owner_e     owner_q;
    logic       core_hold_q;
    logic       rd_pend_q;
    logic       err_q;

    logic fetch_gnt;
    logic ld_gnt;
    logic fetch_mis;
    logic fetch_mem;
    logic at_max;
    logic starve_inc;
    logic fetch_rvalid;
    logic ld_rvalid;
    logic unused_addr_bits;

    // Grants are gated by rst so nothing reaches the macro while reset is held.
    always_comb begin
        fetch_gnt = 1'b0;
        ld_gnt    = 1'b0;
        if (!rst) begin
            case (state)
                BOOT: ld_gnt = bus.ld_req;
                RUN: begin
                    fetch_gnt = bus.fetch_req && !at_max;
                    ld_gnt    = bus.ld_req && !fetch_gnt;
                end
                default: ;
            endcase
        end
    end

`ifdef IMEM_ARB_ALIGN_CHECK_EN
    assign fetch_mis = fetch_gnt && (bus.fetch_addr[1:0] != 2'b00);
`else
    assign fetch_mis = 1'b0;
`endif

    assign fetch_mem     = fetch_gnt && !fetch_mis;
    assign bus.fetch_gnt = fetch_gnt;
    assign bus.ld_gnt    = ld_gnt;
    assign bus.mem_en    = fetch_mem || ld_gnt;
    assign bus.mem_we    = ld_gnt && bus.ld_we;
    assign bus.mem_addr  = fetch_gnt ? bus.fetch_addr[ADDR_W+1:2] :
                           ld_gnt    ? bus.ld_addr[ADDR_W+1:2]    : '0;
    assign bus.mem_wdata = (ld_gnt && bus.ld_we) ? bus.ld_wdata : '0;

    assign unused_addr_bits = ^{bus.fetch_addr[31:ADDR_W+2], bus.fetch_addr[1:0],
                                bus.ld_addr[31:ADDR_W+2], bus.ld_addr[1:0]};

    assign starve_inc = (state == RUN) && bus.ld_req && !ld_gnt;

    imem_starve_counter #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk    (clk),
        .rst    (rst),
        .inc    (starve_inc),
        .clr    (!starve_inc),
        .at_max (at_max)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= BOOT;
            core_hold_q <= 1'b1;
            rd_pend_q   <= 1'b0;
            owner_q     <= OWN_FETCH;
            err_q       <= 1'b0;
        end else begin
            // A misaligned fetch is still a read from the core's view: it gets a response.
            rd_pend_q <= fetch_gnt || (ld_gnt && !bus.ld_we);
            err_q     <= fetch_mis;
            if (fetch_gnt) begin
                owner_q <= OWN_FETCH;
            end else if (ld_gnt && !bus.ld_we) begin
                owner_q <= OWN_LD;
            end
            case (state)
                BOOT: begin
                    if (bus.ld_done) begin
                        state       <= RUN;
                        core_hold_q <= 1'b0;
                    end
                end
                RUN: begin
                    if (bus.ld_halt) begin
                        state       <= DRAIN;
                        core_hold_q <= 1'b1;
                    end
                end
                default: begin
                    if (!rd_pend_q) begin
                        state <= BOOT;
                    end
                end
            endcase
        end
    end

    assign fetch_rvalid     = rd_pend_q && (owner_q == OWN_FETCH);
    assign ld_rvalid        = rd_pend_q && (owner_q == OWN_LD);
    assign bus.fetch_rvalid = fetch_rvalid;
    assign bus.ld_rvalid    = ld_rvalid;
    assign bus.fetch_rdata  = (fetch_rvalid && !err_q) ? bus.mem_rdata : '0;
    assign bus.ld_rdata     = ld_rvalid ? bus.mem_rdata : '0;
    assign bus.core_hold    = core_hold_q;
`ifdef IMEM_ARB_ALIGN_CHECK_EN
    assign bus.fetch_err    = fetch_rvalid && err_q;
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// tb/tb_imem_arbiter.sv - directed self-checking bench for imem_arbiter
module tb_imem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_ldg;

    imem_arbiter_if #(.ADDR_W(10)) bus ();

    imem_arbiter #(
        .ADDR_W     (10),
        .STARVE_MAX (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:1023];
    logic [31:0] mem_q = 32'h0;

    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            else            mem_q <= mem[bus.mem_addr];
        end
    end
    assign bus.mem_rdata = mem_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.fetch_req  = 1'b0;
        bus.fetch_addr = 32'h0;
        bus.ld_req     = 1'b0;
        bus.ld_we      = 1'b0;
        bus.ld_addr    = 32'h0;
        bus.ld_wdata   = 32'h0;
        bus.ld_done    = 1'b0;
        bus.ld_halt    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        idle();
        bus.ld_req = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_core_hold", bus.core_hold, 1);
        check("rst_ld_gnt", bus.ld_gnt, 0);
        check("rst_fetch_gnt", bus.fetch_gnt, 0);
        check("rst_mem_en", bus.mem_en, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_rvalid", {bus.fetch_rvalid, bus.ld_rvalid}, 0);

        rst = 1'b0;
        bus.fetch_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.ld_req   = 1'b1;
            bus.ld_we    = 1'b1;
            bus.ld_addr  = 32'(i * 4);
            bus.ld_wdata = 32'h0000_0013;
            bus.ld_done  = (i == 3);
            #1;
            check("boot_ld_gnt", bus.ld_gnt, 1);
            check("boot_no_fetch", bus.fetch_gnt, 0);
            check("boot_mem_we", bus.mem_we, 1);
            check("boot_mem_addr", bus.mem_addr, i);
            check("boot_hold", bus.core_hold, 1);
            tick();
        end
        bus.ld_req  = 1'b0;
        bus.ld_we   = 1'b0;
        bus.ld_done = 1'b0;
        check("run_hold_low", bus.core_hold, 0);
        check("boot_no_ld_rvalid", bus.ld_rvalid, 0);

        bus.fetch_addr = 32'h4;
        #1;
        check("f4_gnt", bus.fetch_gnt, 1);
        check("f4_mem_en", bus.mem_en, 1);
        check("f4_mem_we", bus.mem_we, 0);
        check("f4_mem_addr", bus.mem_addr, 1);
        tick();
        bus.fetch_addr = 32'h1004;
        check("f4_rvalid", bus.fetch_rvalid, 1);
        check("f4_rdata", bus.fetch_rdata, 32'h0000_0013);
        check("f4_ld_rvalid", bus.ld_rvalid, 0);
        #1;
        check("wrap_mem_addr", bus.mem_addr, 1);
        tick();
        check("wrap_rdata", bus.fetch_rdata, 32'h0000_0013);

        bus.fetch_req = 1'b0;
        bus.ld_req    = 1'b1;
        bus.ld_we     = 1'b1;
        bus.ld_addr   = 32'h10;
        bus.ld_wdata  = 32'hDEAD_BEEF;
        #1;
        check("ldw_gnt", bus.ld_gnt, 1);
        check("ldw_mem_we", bus.mem_we, 1);
        check("ldw_mem_addr", bus.mem_addr, 4);
        check("ldw_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
        tick();
        check("ldw_no_rvalid", {bus.fetch_rvalid, bus.ld_rvalid}, 0);

        bus.ld_req     = 1'b0;
        bus.ld_we      = 1'b0;
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 32'h1010;
        #1;
        check("wrap2_mem_addr", bus.mem_addr, 4);
        tick();
        check("wrap2_rdata", bus.fetch_rdata, 32'hDEAD_BEEF);

        bus.fetch_req = 1'b0;
        bus.ld_req    = 1'b1;
        bus.ld_addr   = 32'h8;
        #1;
        check("ldr_gnt", bus.ld_gnt, 1);
        check("ldr_mem_we", bus.mem_we, 0);
        tick();
        check("ldr_rvalid", bus.ld_rvalid, 1);
        check("ldr_rdata", bus.ld_rdata, 32'h0000_0013);
        check("ldr_no_fetch_rvalid", bus.fetch_rvalid, 0);
        check("ldr_fetch_rdata0", bus.fetch_rdata, 0);

        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 32'h0;
        bus.ld_req     = 1'b1;
        bus.ld_addr    = 32'hC;
        n_ldg = 0;
        for (int i = 0; i < 18; i++) begin
            #1;
            check("starve_ld_gnt", bus.ld_gnt, (i % 9 == 8) ? 1 : 0);
            check("starve_fetch_gnt", bus.fetch_gnt, (i % 9 == 8) ? 0 : 1);
            if (bus.ld_gnt) n_ldg++;
            tick();
        end
        check("starve_ld_total", n_ldg, 2);

        bus.ld_req     = 1'b0;
        bus.fetch_addr = 32'h0;
        bus.ld_halt    = 1'b1;
        #1;
        check("halt_fetch_gnt", bus.fetch_gnt, 1);
        tick();
        bus.ld_halt = 1'b0;
        bus.ld_req  = 1'b1;
        bus.ld_addr = 32'h0;
        #1;
        check("drain1_hold", bus.core_hold, 1);
        check("drain1_rvalid", bus.fetch_rvalid, 1);
        check("drain1_rdata", bus.fetch_rdata, 32'h0000_0013);
        check("drain1_gnts", {bus.fetch_gnt, bus.ld_gnt}, 0);
        tick();
        #1;
        check("drain2_hold", bus.core_hold, 1);
        check("drain2_gnts", {bus.fetch_gnt, bus.ld_gnt}, 0);
        check("drain2_rvalid", bus.fetch_rvalid, 0);
        tick();
        #1;
        check("reboot_ld_gnt", bus.ld_gnt, 1);
        check("reboot_fetch_gnt", bus.fetch_gnt, 0);
        check("reboot_hold", bus.core_hold, 1);

        #2;
        rst = 1'b1;
        #1;
        check("midrst_gnt", bus.ld_gnt, 0);
        check("midrst_mem_en", bus.mem_en, 0);
        tick();
        check("midrst_ld_rvalid", bus.ld_rvalid, 0);
        check("midrst_hold", bus.core_hold, 1);
        rst = 1'b0;
        #1;
        check("postrst_ld_gnt", bus.ld_gnt, 1);
        check("postrst_fetch_gnt", bus.fetch_gnt, 0);

        bus.ld_req  = 1'b0;
        bus.ld_done = 1'b1;
        tick();
        bus.ld_done = 1'b0;
        check("rerun_hold", bus.core_hold, 0);
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 32'h6;
`ifdef IMEM_ARB_ALIGN_CHECK_EN
        #1;
        check("mis_gnt", bus.fetch_gnt, 1);
        check("mis_mem_en", bus.mem_en, 0);
        tick();
        check("mis_rvalid", bus.fetch_rvalid, 1);
        check("mis_err", bus.fetch_err, 1);
        check("mis_rdata", bus.fetch_rdata, 0);
        #1;
        check("mis2_gnt", bus.fetch_gnt, 1);
        rst = 1'b1;
        tick();
        check("mis2_rst_rvalid", bus.fetch_rvalid, 0);
        check("mis2_rst_err", bus.fetch_err, 0);
        check("mis2_rst_hold", bus.core_hold, 1);
        rst = 1'b0;
`else
        #1;
        check("unal_gnt", bus.fetch_gnt, 1);
        check("unal_mem_en", bus.mem_en, 1);
        check("unal_mem_addr", bus.mem_addr, 1);
        tick();
        check("unal_rvalid", bus.fetch_rvalid, 1);
        check("unal_rdata", bus.fetch_rdata, 32'h0000_0013);
`endif
        idle();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Sequencer and arbiter for the shared single-port instruction memory. Holds the core in `core_hold` while a program loader fills memory, then shares the port between the core fetch path and the loader. Fetch has priority; a starvation counter bounds loader wait. Sits between the core's fetch stage and loader on one side and the instruction memory macro (synchronous read, 1-cycle latency) on the other.

## Interface
Parameters:
- `ADDR_W`, 10: word-address width of the memory.
- `STARVE_MAX`, 8: consecutive denied loader cycles before the loader is forced a grant (≥1).

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset, asynchronous, active-high.
- `fetch_req` in 1: core requests a read.
- `fetch_addr` in 32: byte address.
- `fetch_gnt` out 1: request accepted this cycle.
- `fetch_rvalid` out 1: read data valid.
- `fetch_rdata` out 32: instruction word.
- `fetch_err` out 1: misaligned-fetch response, only with `IMEM_ARB_ALIGN_CHECK_EN`.
- `ld_req` in 1: loader access request.
- `ld_we` in 1: 1 means write, 0 means read.
- `ld_addr` in 32: byte address.
- `ld_wdata` in 32: write data.
- `ld_gnt` out 1: loader access accepted.
- `ld_rvalid` out 1: loader read data valid.
- `ld_rdata` out 32: read data.
- `ld_done` in 1: pulse that ends the load phase.
- `ld_halt` in 1: pulse requesting re-entry to the load phase.
- `core_hold` out 1: core must stay in reset or stall.
- `mem_en` out 1: memory access strobe.
- `mem_we` out 1: write strobe.
- `mem_addr` out ADDR_W: word address.
- `mem_wdata` out 32: write data.
- `mem_rdata` in 32: memory read data, valid the cycle after `mem_en` with `mem_we`=0.

## Operation
States are BOOT, RUN and DRAIN. Reset enters BOOT.

BOOT:
- Only the loader is granted: `ld_gnt`=`ld_req`. `fetch_gnt`=0. `core_hold`=1.
- `ld_done` moves the state to RUN next cycle.
- An `ld_req` in the same cycle as `ld_done` is still granted.

RUN:
- `core_hold`=0.
- If `fetch_req` and the starve counter is below `STARVE_MAX`, fetch is granted.
- Otherwise, if `ld_req`, the loader is granted.
- The starve counter increments each cycle `ld_req`=1 and the loader is denied.
- It clears on a loader grant or when `ld_req`=0, and saturates at `STARVE_MAX`.
- When the counter reaches `STARVE_MAX`, the loader wins the next arbitration even if `fetch_req`=1.
- `ld_halt` moves the state to DRAIN. If `ld_halt` and `ld_done` coincide, `ld_halt` wins.

DRAIN:
- No new grants. `core_hold`=1.
- Waits until no read response is outstanding (at most 1 cycle), then enters BOOT.

Common rules:
- At most one grant per cycle. `mem_en`=`fetch_gnt`|`ld_gnt`.
- `mem_we`=`ld_gnt`&`ld_we`.
- `mem_addr` is the granted requester's address bits [ADDR_W+1:2]. Upper bits are ignored, so addresses wrap modulo 4·2^ADDR_W bytes.
- A registered owner tag records who issued each read. The response is routed to that owner only.
- `*_rdata`=`mem_rdata` when the matching `*_rvalid`=1, else 0.
- Loader writes produce no `ld_rvalid`.
- `rst` asserted mid-operation aborts everything: pending responses are discarded and the state returns to BOOT.

## Timing
- Grants are combinational from requests and the registered state, in the same cycle as the request.
- `*_rvalid` is registered, exactly 1 cycle after the read grant. Back-to-back reads give one response per cycle.
- A requester holds its request until granted. Address and data must be stable in the grant cycle only.
- Reset values:
  - state is BOOT, `core_hold`=1;
  - all grants, rvalids, `mem_en`, `mem_we` and `fetch_err` are 0;
  - starve counter and owner tag are 0;
  - `mem_addr` and `mem_wdata` are 0.
- BOOT to RUN: `core_hold` falls the cycle after `ld_done`.
- RUN to DRAIN: `core_hold` rises the cycle after `ld_halt`.
- DRAIN to BOOT takes 1 cycle, or 2 if a read was granted in the `ld_halt` cycle.

## Configuration
- `IMEM_ARB_ALIGN_CHECK_EN` defined:
  - A RUN fetch with `fetch_addr[1:0]`≠0 still gets `fetch_gnt`=1, but `mem_en` stays 0.
  - Next cycle it returns `fetch_rvalid`=1, `fetch_err`=1, `fetch_rdata`=0.
  - The starve counter treats this cycle as a fetch grant.
- `IMEM_ARB_ALIGN_CHECK_EN` undefined:
  - `fetch_addr[1:0]` is ignored.
  - The `fetch_err` port is absent.

## Structure
- Package `imem_arb_pkg` holds:
  - the state enum (BOOT, RUN, DRAIN);
  - the owner-tag enum (OWN_FETCH, OWN_LD);
  - the default `STARVE_MAX` constant.
- One sub-module: `imem_starve_counter`, a saturating counter with inc, clr and `at_max` outputs, parameterised by `STARVE_MAX`.

## Test plan
- Reset, loader writes 0x00000013 to addresses 0x0..0xC, then `ld_done`: `core_hold` 1→0 one cycle after `ld_done`, and no `fetch_gnt` before that.
- RUN, fetch of 0x4: `fetch_gnt` in the same cycle; next cycle `fetch_rvalid`=1 and `fetch_rdata`=0x00000013. `ld_rvalid` stays 0.
- RUN, `fetch_req` and `ld_req` held high continuously with `STARVE_MAX`=8: the loader is granted once every 9 cycles, and fetch gets the other 8.
- Fetch read granted in the same cycle as `ld_halt`: the response is still delivered, DRAIN lasts 2 cycles, then BOOT. `fetch_gnt` stays 0 afterwards.
- Address 0x1004 with `ADDR_W`=10: `mem_addr`=1, because the address wraps.
- With `IMEM_ARB_ALIGN_CHECK_EN`, fetch of 0x6: `mem_en`=0, then `fetch_err`=1 and `fetch_rdata`=0 next cycle. Assert `rst` mid-read: no rvalid, and the state is BOOT.
